// File: rtl/bus_invert_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : bus_invert_receiver
//  Description : Receive side of a bus-invert link. Decodes each sampled word
//                (data XOR {WIDTH{invert}}), buffers it in a show-ahead FIFO
//                and hands it downstream over valid/ready. Words arriving on
//                a full FIFO are dropped and flagged with a sticky overflow.
//                Optional activity counters are built when the macro
//                BI_ACTIVITY_CNT_EN is defined; otherwise they read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_invert_receiver #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bus_valid,
    input  logic [WIDTH-1:0]                bus_data,
    input  logic                            bus_invert,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow,
    output logic [CNT_W-1:0]                link_toggles,
    output logic [CNT_W-1:0]                raw_toggles
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] decoded;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign decoded = bus_data ^ {WIDTH{bus_invert}};
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // out_valid comes from registered pointers only, so out_ready never reaches an output
    assign pop     = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign push    = bus_valid && (!full || pop);
    assign drop    = bus_valid && full && !pop;

    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign fifo_level = wr_ptr - rd_ptr;

    // Storage array; contents are only visible through out_data when non-empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= decoded;
        end
    end

    // Pointer and sticky overflow update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef BI_ACTIVITY_CNT_EN
    localparam int PW = $clog2(WIDTH + 2);

    logic [WIDTH:0]   prev_link;
    logic [WIDTH-1:0] prev_decoded;
    logic [CNT_W-1:0] link_cnt;
    logic [CNT_W-1:0] raw_cnt;
    logic [CNT_W:0]   link_sum;
    logic [CNT_W:0]   raw_sum;

    function automatic logic [PW-1:0] popcount(input logic [WIDTH:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    // Candidate counter values one bit wider so saturation can be detected
    always_comb begin
        link_sum = {1'b0, link_cnt} + (CNT_W+1)'(popcount({bus_invert, bus_data} ^ prev_link));
        raw_sum  = {1'b0, raw_cnt}  + (CNT_W+1)'(popcount({1'b0, decoded ^ prev_decoded}));
    end

    // Count wire activity on every sampled word, dropped words included
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_link    <= '0;
            prev_decoded <= '0;
            link_cnt     <= '0;
            raw_cnt      <= '0;
        end else if (bus_valid) begin
            prev_link    <= {bus_invert, bus_data};
            prev_decoded <= decoded;
            link_cnt     <= link_sum[CNT_W] ? {CNT_W{1'b1}} : link_sum[CNT_W-1:0];
            raw_cnt      <= raw_sum[CNT_W]  ? {CNT_W{1'b1}} : raw_sum[CNT_W-1:0];
        end
    end

    assign link_toggles = link_cnt;
    assign raw_toggles  = raw_cnt;
`else
    assign link_toggles = '0;
    assign raw_toggles  = '0;
`endif

endmodule
`default_nettype wire
